// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps a 4:1 mux select across the enabled channels, holds each
// channel dwell+1 cycles, samples the mux output into a shadow word and publishes
// one word per completed frame (single-shot or continuous).
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start, stop     begin scanning (IDLE only) / abort from any state
//   cont            1 = continuous frames, 0 = single frame (latched per frame)
//   dwell           extra hold cycles per channel (latched per frame)
//   en_mask         channel enables (latched per frame)
//   f_in            downstream mux output, sampled at the end of each dwell
//   sin             channel select to the mux
//   word            last completed frame, disabled channels read 0
//   word_valid      one-cycle pulse when word updates
//   busy            high while scanning
//   frames          completed-frame count, wraps at 256
module mux_scan_ctrl #(
    parameter int unsigned DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               cont,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [3:0]         en_mask,
    input  logic               f_in,
    output logic [1:0]         sin,
    output logic [3:0]         word,
    output logic               word_valid,
    output logic               busy,
    output logic [7:0]         frames
);

    localparam int unsigned NCH = 4;
    localparam int unsigned FW  = 8;

    typedef enum logic {S_IDLE, S_SCAN} state_t;

    state_t             state_q, state_d;
    logic [1:0]         sin_q, sin_d;
    logic [NCH-1:0]     word_q, word_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic [FW-1:0]      frames_q, frames_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwl_q, dwl_d;
    logic [NCH-1:0]     mask_q, mask_d;
    logic               cont_q, cont_d;
    logic [NCH-1:0]     shadow_q, shadow_d;
    logic [NCH-1:0]     shadow_smp;

    // Lowest set bit of m (0 when m is empty; callers guarantee m != 0).
    function automatic logic [1:0] lowest_ch(input logic [NCH-1:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Next set bit strictly above cur; cur when none exists.
    function automatic logic [1:0] next_ch(input logic [NCH-1:0] m, input logic [1:0] cur);
        logic [1:0] r;
        r = cur;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i] && (i > int'(cur))) r = 2'(i);
        end
        return r;
    endfunction

    // True when some enabled channel lies above cur, i.e. the frame is not finished.
    function automatic logic has_next(input logic [NCH-1:0] m, input logic [1:0] cur);
        logic r;
        r = 1'b0;
        for (int i = 0; i < int'(NCH); i++) begin
            if (m[i] && (i > int'(cur))) r = 1'b1;
        end
        return r;
    endfunction

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        sin_d      = sin_q;
        word_d     = word_q;
        valid_d    = 1'b0;
        busy_d     = busy_q;
        frames_d   = frames_q;
        cnt_d      = cnt_q;
        dwl_d      = dwl_q;
        mask_d     = mask_q;
        cont_d     = cont_q;
        shadow_d   = shadow_q;
        shadow_smp = shadow_q;
        shadow_smp[sin_q] = f_in;

        case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                sin_d  = 2'd0;
                busy_d = 1'b0;
                if (start && !stop && (en_mask != '0)) begin
                    state_d  = S_SCAN;
                    mask_d   = en_mask;
                    dwl_d    = dwell;
                    cont_d   = cont;
                    sin_d    = lowest_ch(en_mask);
                    shadow_d = '0;
                    busy_d   = 1'b1;
                end
            end
            S_SCAN: begin
                if (stop) begin
                    // Abort: partial shadow dropped, published state untouched.
                    state_d  = S_IDLE;
                    sin_d    = 2'd0;
                    busy_d   = 1'b0;
                    cnt_d    = '0;
                    shadow_d = '0;
                end else if (cnt_q == dwl_q) begin
                    cnt_d    = '0;
                    shadow_d = shadow_smp;
                    if (!has_next(mask_q, sin_q)) begin
                        word_d   = shadow_smp & mask_q;
                        valid_d  = 1'b1;
                        frames_d = frames_q + FW'(1);
                        if (cont_q && (en_mask != '0)) begin
                            // Back-to-back frame with freshly latched settings.
                            mask_d   = en_mask;
                            dwl_d    = dwell;
                            cont_d   = cont;
                            sin_d    = lowest_ch(en_mask);
                            shadow_d = '0;
                        end else begin
                            state_d  = S_IDLE;
                            sin_d    = 2'd0;
                            busy_d   = 1'b0;
                            shadow_d = '0;
                        end
                    end else begin
                        sin_d = next_ch(mask_q, sin_q);
                    end
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                sin_d   = 2'd0;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sin_q    <= 2'd0;
            word_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            frames_q <= '0;
            cnt_q    <= '0;
            dwl_q    <= '0;
            mask_q   <= '0;
            cont_q   <= 1'b0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            sin_q    <= sin_d;
            word_q   <= word_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            frames_q <= frames_d;
            cnt_q    <= cnt_d;
            dwl_q    <= dwl_d;
            mask_q   <= mask_d;
            cont_q   <= cont_d;
            shadow_q <= shadow_d;
        end
    end

    assign sin        = sin_q;
    assign word       = word_q;
    assign word_valid = valid_q;
    assign busy       = busy_q;
    assign frames     = frames_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: directed vector table, hand-written corner sequences and
// randomized traffic, all checked against a frame-level reference model.
module tb_mux_scan_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       cont;
    logic [3:0] dwell;
    logic [3:0] en_mask;
    logic       f_in;
    logic [1:0] sin;
    logic [3:0] word;
    logic       word_valid;
    logic       busy;
    logic [7:0] frames;
    logic [3:0] mux_data;

    int n_checks = 0;
    int n_fail   = 0;

    // Downstream 4:1 mux driven by the DUT's select.
    assign f_in = mux_data[sin];

    mux_scan_ctrl #(.DWELL_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .cont       (cont),
        .dwell      (dwell),
        .en_mask    (en_mask),
        .f_in       (f_in),
        .sin        (sin),
        .word       (word),
        .word_valid (word_valid),
        .busy       (busy),
        .frames     (frames)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a frame is a list of enabled channels, each held dwell+1
    // cycles; m_k is the cycle index within the current frame.
    bit         m_busy;
    int         m_chans[$];
    int         m_dwell;
    bit         m_cont;
    int         m_k;
    logic [3:0] m_shadow;
    logic [3:0] m_word;
    bit         m_valid;
    int         m_frames;

    task automatic model_reset();
        m_busy = 0; m_k = 0; m_shadow = 4'h0; m_word = 4'h0;
        m_valid = 0; m_frames = 0; m_dwell = 0; m_cont = 0;
        m_chans.delete();
    endtask

    task automatic model_begin();
        m_chans.delete();
        for (int i = 0; i < 4; i++) if (en_mask[i]) m_chans.push_back(i);
        m_dwell = int'(dwell);
        m_cont = cont;
        m_k = 0;
        m_shadow = 4'h0;
        m_busy = 1;
    endtask

    function automatic int model_sin();
        if (!m_busy) return 0;
        return m_chans[m_k / (m_dwell + 1)];
    endfunction

    task automatic model_step();
        int ch;
        int len;
        m_valid = 0;
        if (!m_busy) begin
            if (start && !stop && en_mask != 4'h0) model_begin();
        end else if (stop) begin
            m_busy = 0;
        end else begin
            len = m_chans.size() * (m_dwell + 1);
            if ((m_k % (m_dwell + 1)) == m_dwell) begin
                ch = model_sin();
                m_shadow[ch] = mux_data[ch];
            end
            m_k++;
            if (m_k == len) begin
                m_word = m_shadow;
                m_valid = 1;
                m_frames = (m_frames + 1) % 256;
                if (m_cont && en_mask != 4'h0) model_begin();
                else m_busy = 0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_sin"},   32'(sin),        32'(model_sin()));
        chk({tag, "_busy"},  32'(busy),       32'(m_busy));
        chk({tag, "_word"},  32'(word),       32'(m_word));
        chk({tag, "_valid"}, 32'(word_valid), 32'(m_valid));
        chk({tag, "_frames"},32'(frames),     32'(m_frames));
    endtask

    // Advance one clock with the current inputs; returns 1 time unit after the edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_chk(input string tag);
        tick();
        check_model(tag);
    endtask

    // Pulse reset between clock edges and clear inputs.
    task automatic do_reset();
        start = 0; stop = 0; cont = 0; dwell = 0; en_mask = 0; mux_data = 0;
        rst = 1;
        #2;
        rst = 0;
        model_reset();
    endtask

    typedef struct {
        logic       start;
        logic [3:0] mask;
        logic [3:0] data;
        logic [1:0] e_sin;
        logic       e_busy;
        logic [3:0] e_word;
        logic       e_valid;
        logic [7:0] e_frames;
    } vec_t;

    vec_t vecs[8];

    initial begin
        // Single frame over all channels, then start attempts with an empty mask.
        vecs[0] = '{1'b1, 4'hF, 4'hA, 2'd0, 1'b1, 4'h0, 1'b0, 8'd0};
        vecs[1] = '{1'b0, 4'hF, 4'hA, 2'd1, 1'b1, 4'h0, 1'b0, 8'd0};
        vecs[2] = '{1'b0, 4'hF, 4'hA, 2'd2, 1'b1, 4'h0, 1'b0, 8'd0};
        vecs[3] = '{1'b0, 4'hF, 4'hA, 2'd3, 1'b1, 4'h0, 1'b0, 8'd0};
        vecs[4] = '{1'b0, 4'hF, 4'hA, 2'd0, 1'b0, 4'hA, 1'b1, 8'd1};
        vecs[5] = '{1'b0, 4'hF, 4'hA, 2'd0, 1'b0, 4'hA, 1'b0, 8'd1};
        vecs[6] = '{1'b1, 4'h0, 4'hF, 2'd0, 1'b0, 4'hA, 1'b0, 8'd1};
        vecs[7] = '{1'b1, 4'h0, 4'h5, 2'd0, 1'b0, 4'hA, 1'b0, 8'd1};

        rst = 1; start = 0; stop = 0; cont = 0; dwell = 0; en_mask = 0; mux_data = 0;
        model_reset();
        #12;
        chk("rst_sin", 32'(sin), 0);
        chk("rst_word", 32'(word), 0);
        chk("rst_valid", 32'(word_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frames", 32'(frames), 0);
        rst = 0;

        // Directed vector table.
        for (int i = 0; i < 8; i++) begin
            start = vecs[i].start; en_mask = vecs[i].mask; mux_data = vecs[i].data;
            tick();
            chk($sformatf("vec%0d_sin", i),    32'(sin),        32'(vecs[i].e_sin));
            chk($sformatf("vec%0d_busy", i),   32'(busy),       32'(vecs[i].e_busy));
            chk($sformatf("vec%0d_word", i),   32'(word),       32'(vecs[i].e_word));
            chk($sformatf("vec%0d_valid", i),  32'(word_valid), 32'(vecs[i].e_valid));
            chk($sformatf("vec%0d_frames", i), 32'(frames),     32'(vecs[i].e_frames));
        end

        // Sparse mask with dwell 2: six-cycle frame.
        do_reset();
        en_mask = 4'b0101; dwell = 2; mux_data = 4'hF; start = 1;
        tick_chk("s32_start");
        start = 0;
        for (int i = 1; i <= 6; i++) tick_chk("s32");
        chk("s32_word", 32'(word), 32'h5);
        chk("s32_valid", 32'(word_valid), 1);
        chk("s32_busy", 32'(busy), 0);

        // Continuous mode: three back-to-back two-cycle frames.
        do_reset();
        en_mask = 4'b0011; dwell = 0; mux_data = 4'hF; cont = 1; start = 1;
        tick_chk("s33_start");
        start = 0;
        for (int i = 1; i <= 6; i++) begin
            if (i == 4) cont = 0;
            tick_chk("s33");
            chk("s33_pulse", 32'(word_valid), 32'((i % 2) == 0));
        end
        chk("s33_frames", 32'(frames), 3);
        chk("s33_busy", 32'(busy), 0);

        // Stop mid-frame, then stop coincident with the final sample.
        do_reset();
        en_mask = 4'hF; dwell = 1; mux_data = 4'b0110; start = 1;
        tick_chk("s34_a");
        start = 0;
        for (int i = 0; i < 8; i++) tick_chk("s34_a");
        chk("s34_first_word", 32'(word), 32'h6);
        mux_data = 4'b1001; start = 1;
        tick_chk("s34_b");
        start = 0;
        tick_chk("s34_b");
        tick_chk("s34_b");
        chk("s34_second_ch", 32'(sin), 1);
        stop = 1;
        tick_chk("s34_b");
        stop = 0;
        chk("s34_stop_word", 32'(word), 32'h6);
        chk("s34_stop_busy", 32'(busy), 0);
        en_mask = 4'b0011; start = 1;
        tick_chk("s34_c");
        start = 0;
        for (int i = 0; i < 3; i++) tick_chk("s34_c");
        stop = 1;
        tick_chk("s34_c");
        stop = 0;
        chk("s34_final_valid", 32'(word_valid), 0);
        chk("s34_final_word", 32'(word), 32'h6);
        chk("s34_final_frames", 32'(frames), 1);

        // Asynchronous reset mid-frame, then no restart without a new start.
        en_mask = 4'hF; dwell = 3; mux_data = 4'hF; start = 1;
        tick_chk("s35");
        start = 0;
        for (int i = 0; i < 5; i++) tick_chk("s35");
        rst = 1;
        #2;
        chk("s35_async_sin", 32'(sin), 0);
        chk("s35_async_word", 32'(word), 0);
        chk("s35_async_valid", 32'(word_valid), 0);
        chk("s35_async_busy", 32'(busy), 0);
        chk("s35_async_frames", 32'(frames), 0);
        rst = 0;
        model_reset();
        tick_chk("s35_after");
        tick_chk("s35_after");

        // Frame counter wrap: 256 one-cycle frames.
        do_reset();
        en_mask = 4'b0001; dwell = 0; cont = 1; mux_data = 4'h1; start = 1;
        tick_chk("s36_wrap");
        start = 0;
        for (int i = 0; i < 256; i++) tick_chk("s36_wrap");
        chk("s36_wrapped", 32'(frames), 0);
        stop = 1;
        tick_chk("s36_wrap");
        stop = 0;

        // Mask change mid-frame applies only at the next boundary.
        do_reset();
        en_mask = 4'b0011; dwell = 1; cont = 1; mux_data = 4'hF; start = 1;
        tick_chk("s36_mask");
        start = 0;
        tick_chk("s36_mask");
        en_mask = 4'b1100;
        tick_chk("s36_mask");
        tick_chk("s36_mask");
        chk("s36_old_mask", 32'(sin), 1);
        tick_chk("s36_mask");
        chk("s36_new_mask", 32'(sin), 2);
        chk("s36_new_word", 32'(word), 32'h3);
        stop = 1;
        tick_chk("s36_mask");
        stop = 0;

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            start    = ($urandom_range(0, 3) == 0);
            stop     = ($urandom_range(0, 23) == 0);
            cont     = 1'($urandom_range(0, 1));
            dwell    = 4'($urandom_range(0, 3));
            en_mask  = 4'($urandom_range(0, 15));
            mux_data = 4'($urandom_range(0, 15));
            tick_chk("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
